// File: rtl/comparator_pkg.sv
// Shared types for the comparator search controller: FSM states, comparator flag
// bundle and the one-hot check applied to the flags.
package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } search_state_t;

  typedef struct packed {
    logic less;
    logic equal;
    logic greater;
  } cmp_flags_t;

  // True when exactly one of the three comparator flags is set.
  function automatic logic onehot3(input cmp_flags_t f);
    return (f.less ^ f.equal ^ f.greater) & ~(f.less & f.equal & f.greater);
  endfunction

endpackage

// File: rtl/comparator_search_ctrl.sv
// Binary-search controller: drives the comparator probe operand and narrows
// [lo, hi] on each less/equal/greater answer until the target is located.
import comparator_pkg::*;

module comparator_search_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             less,
  input  logic             equal,
  input  logic             greater,
  output logic [WIDTH-1:0] probe,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             error,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       dbg_state
);

  // Handshake: start is a level sampled only in IDLE (ignored otherwise, never
  // queued); done is a one-cycle pulse, found/error/result valid with it and
  // held until the next accepted start.
  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH:0]   ONE = {{WIDTH{1'b0}}, 1'b1};

  search_state_t    state, state_n;
  logic [WIDTH:0]   lo, hi, lo_n, hi_n;
  logic [WIDTH-1:0] probe_n, result_n;
  logic             found_n, error_n;
  logic             miss;
  cmp_flags_t       flags;

  assign flags     = {less, equal, greater};
  assign busy      = (state == PROBE);
  assign done      = (state == DONE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      lo     <= '0;
      hi     <= {1'b0, MAX};
      probe  <= '0;
      found  <= 1'b0;
      error  <= 1'b0;
      result <= '0;
    end else begin
      state  <= state_n;
      lo     <= lo_n;
      hi     <= hi_n;
      probe  <= probe_n;
      found  <= found_n;
      error  <= error_n;
      result <= result_n;
    end
  end

  always_comb begin
    state_n  = state;
    lo_n     = lo;
    hi_n     = hi;
    probe_n  = probe;
    found_n  = found;
    error_n  = error;
    result_n = result;
    miss     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          lo_n    = '0;
          hi_n    = {1'b0, MAX};
          probe_n = MAX >> 1;
          found_n = 1'b0;
          error_n = 1'b0;
          state_n = PROBE;
        end
      end
      PROBE: begin
        if (!onehot3(flags)) begin
          error_n  = 1'b1;
          found_n  = 1'b0;
          result_n = '0;
          state_n  = DONE;
        end else if (flags.equal) begin
          found_n  = 1'b1;
          result_n = probe;
          state_n  = DONE;
        end else begin
          // Edges of the range are checked explicitly so lo/hi never wrap.
          if (flags.less) begin
            if (probe == '0) miss = 1'b1;
            else             hi_n = {1'b0, probe} - ONE;
          end else begin
            if (probe == MAX) miss = 1'b1;
            else              lo_n = {1'b0, probe} + ONE;
          end
          if (miss || (lo_n > hi_n)) begin
            found_n  = 1'b0;
            result_n = '0;
            state_n  = DONE;
          end else begin
            probe_n = WIDTH'((lo_n + hi_n) >> 1);
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_comparator_search_ctrl.sv
// Self-checking bench for comparator_search_ctrl: an integer binary-search model
// predicts probes and results, a per-cycle compare process checks the DUT.
module tb_comparator_search_ctrl;

  localparam int W   = 4;
  localparam int MAX = (1 << W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT and comparator stand-in ----------------
  logic [W-1:0] probe, result;
  logic         busy, done, found, error;
  logic [1:0]   dbg_state;
  logic         less, equal, greater;
  int           target = 0;
  int           mode = 0;   // 0 real comparator, 1 less+greater, 2 stuck less

  always_comb begin
    less = 1'b0; equal = 1'b0; greater = 1'b0;
    case (mode)
      1:       begin less = 1'b1; greater = 1'b1; end
      2:       less = 1'b1;
      default: begin
        less    = (target <  int'(probe));
        equal   = (target == int'(probe));
        greater = (target >  int'(probe));
      end
    endcase
  end

  comparator_search_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .less(less), .equal(equal), .greater(greater),
    .probe(probe), .busy(busy), .done(done), .found(found),
    .error(error), .result(result), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  int  exp_found, exp_error, exp_result, n_exp;
  int  hold_found = 0, hold_error = 0, hold_result = 0;
  bit  hold_valid = 1'b0;
  bit  chk_en = 1'b0;
  bit  done_seen = 1'b0;
  int  done_cyc = 0;
  int  t0 = 0;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: plain integer binary search over 0..MAX driven by the flag rules.
  task automatic model(input int tgt, input int md);
    int lo, hi, p, l, e, g;
    lo = 0; hi = MAX;
    exp_q.delete();
    exp_found = 0; exp_error = 0; exp_result = 0; n_exp = 0;
    forever begin
      p = (lo + hi) / 2;
      exp_q.push_back(p[W-1:0]);
      n_exp++;
      if (md == 1)      begin l = 1; e = 0; g = 1; end
      else if (md == 2) begin l = 1; e = 0; g = 0; end
      else begin
        l = int'(tgt < p); e = int'(tgt == p); g = int'(tgt > p);
      end
      if (l + e + g != 1) begin exp_error = 1; break; end
      if (e == 1) begin exp_found = 1; exp_result = p; break; end
      if (l == 1) hi = p - 1;
      else        lo = p + 1;
      if (lo > hi) break;
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy_done_exclusive", int'(busy & done), 0);
      if (busy) begin
        obs_q.push_back(probe);
        if (exp_q.size() == 0) check("probe_extra", int'(probe), -1);
        else                   check("probe", int'(probe), int'(exp_q.pop_front()));
      end
      if (done) begin
        check("probes_left", exp_q.size(), 0);
        check("found", int'(found), exp_found);
        check("error", int'(error), exp_error);
        check("result", int'(result), exp_result);
        hold_found = exp_found; hold_error = exp_error; hold_result = exp_result;
        hold_valid = 1'b1;
        done_seen  = 1'b1;
        done_cyc   = cyc;
      end else if (!busy && hold_valid) begin
        check("hold_found", int'(found), hold_found);
        check("hold_error", int'(error), hold_error);
        check("hold_result", int'(result), hold_result);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_search(input int tgt, input int md, input bit poke);
    model(tgt, md);
    obs_q.delete();
    done_seen = 1'b0;
    @(posedge clk); #1;
    target = tgt; mode = md; start = 1'b1; t0 = cyc;
    @(posedge clk); #1;
    start = poke;          // start while busy must be ignored
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 20 && !done_seen; i++) @(posedge clk);
    if (!done_seen) check("done_timeout", 0, 1);
    else            check("latency", done_cyc - t0, n_exp + 1);
    @(posedge clk); #1;
  endtask

  task automatic check_obs(input string name, input int a, input int b, input int c, input int d);
    check({name, "_len"}, obs_q.size(), 4);
    if (obs_q.size() == 4) begin
      check({name, "_p0"}, int'(obs_q[0]), a);
      check({name, "_p1"}, int'(obs_q[1]), b);
      check({name, "_p2"}, int'(obs_q[2]), c);
      check({name, "_p3"}, int'(obs_q[3]), d);
    end
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_probe"}, int'(probe), 0);
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_done"}, int'(done), 0);
    check({name, "_found"}, int'(found), 0);
    check({name, "_error"}, int'(error), 0);
    check({name, "_result"}, int'(result), 0);
    check({name, "_state"}, int'(dbg_state), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int saw_done;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_vals("reset");
    chk_en = 1'b1;
    hold_valid = 1'b1;

    // Directed cases with literal expectations pinning the model.
    run_search(10, 0, 1'b0);
    check_obs("t10", 7, 11, 9, 10);
    check("t10_latency_lit", done_cyc - t0, 5);
    check("t10_result_lit", int'(result), 10);

    run_search(15, 0, 1'b0);
    check("t15_latency_lit", done_cyc - t0, 6);
    check("t15_found_lit", int'(found), 1);

    run_search(0, 0, 1'b0);
    check_obs("t0", 7, 3, 1, 0);
    check("t0_latency_lit", done_cyc - t0, 5);

    run_search(5, 1, 1'b0);
    check("err_latency_lit", done_cyc - t0, 2);
    check("err_error_lit", int'(error), 1);
    check("err_found_lit", int'(found), 0);

    run_search(9, 2, 1'b0);
    check_obs("stuck", 7, 3, 1, 0);
    check("stuck_latency_lit", done_cyc - t0, 5);
    check("stuck_found_lit", int'(found), 0);
    check("stuck_error_lit", int'(error), 0);

    // Reset mid-search with a start pulsed while busy.
    chk_en = 1'b0;
    @(posedge clk); #1;
    target = 10; mode = 0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("midreset");
    saw_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    check("midreset_quiet", saw_done, 0);
    hold_found = 0; hold_error = 0; hold_result = 0;
    chk_en = 1'b1;
    run_search(10, 0, 1'b0);
    check("after_reset_latency_lit", done_cyc - t0, 5);
    check("after_reset_result_lit", int'(result), 10);

    // Randomized targets and modes, some with start poked while busy.
    for (int k = 0; k < 40; k++) begin
      int md;
      md = ($urandom_range(0, 9) < 8) ? 0 : int'($urandom_range(1, 2));
      run_search(int'($urandom_range(0, MAX)), md, 1'($urandom_range(0, 1)));
    end

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
